omsp_spm_protect_ctrl: RTL and testbench
========================================

# omsp_spm_protect_ctrl

Multi-cycle sequencer for SPM create (protect) and destroy (unprotect) requests. It sits between the execution unit and the SPM control/array logic. On a request it latches the layout registers, validates the layout against the array state, and issues a single-cycle `update_spm`/`enable_spm` command. It then returns a result word and a done pulse, and allocates monotonically increasing SPM IDs.

## Interface
- `NB_SPMS`, default 4: number of SPM slots in the array.
- `ID_W`, default 16: SPM ID / result width.

Ports:
- `mclk` in 1: core clock.
- `puc_rst` in 1: reset, asynchronous, active-high.
- `req_protect` in 1: protect request, one-cycle pulse from decode.
- `req_unprotect` in 1: unprotect request, one-cycle pulse from decode.
- `r12`–`r15` in 16 each: layout operands:
  - `r12`: public start.
  - `r13`: public end.
  - `r14`: secret start.
  - `r15`: secret end.
- `spms_enabled` in NB_SPMS: enabled vector from the SPM array.
- `spms_overlap` in NB_SPMS: per-slot overlap flag, combinational on `r12`–`r15` as driven by the latched operands (`lay_*`).
- `violation` in 1: any SPM access violation.
- `lay_pub_start`, `lay_pub_end`, `lay_sec_start`, `lay_sec_end` out 16 each: latched operands to the array.
- `update_spm` out 1: array update strobe.
- `enable_spm` out 1: 1 for create, 0 for destroy.
- `spm_id` out ID_W: ID given to the slot being created.
- `busy` out 1: request in progress; the frontend stalls.
- `done` out 1: one-cycle completion pulse.
- `result` out ID_W: result, valid while `done` is high.

## Operation
States: IDLE, VALIDATE, COMMIT, DONE.

IDLE:
- On `req_protect` xor `req_unprotect`: latch `r12`–`r15` into `lay_*`, latch the operation type, go to VALIDATE.
- Both requests asserted together: go to DONE with `fail` set; no update is issued.

VALIDATE:
- For protect, `ok` requires all of:
  - `pub_start < pub_end`
  - `sec_start <= sec_end`
  - regions disjoint: `sec_end <= pub_start` or `sec_start >= pub_end`
  - `~&spms_enabled` (a slot is free)
  - `~|spms_overlap`
- For unprotect: always `ok`.
- `ok` and `!violation`: go to COMMIT. Otherwise go to DONE with `fail` set.

COMMIT:
- Assert `update_spm` for one cycle.
- `enable_spm` equals the latched operation (1 = protect).
- `spm_id` = `next_id`.
- Go to DONE.

DONE:
- Assert `done` for one cycle, then go to IDLE.
- Result values:
  - Successful protect: `result` = assigned ID.
  - Successful unprotect: `result` = 1.
  - Any fail: `result` = 0.

ID counter:
- `next_id` resets to 1.
- Increments only on a successful protect commit.
- Wraps from `2^ID_W-1` to 1; 0 is never issued.

`busy` is high in VALIDATE, COMMIT and DONE. Requests arriving while `busy` is high are ignored (not queued).

## Timing
Reset values:
- State = IDLE.
- `update_spm`, `enable_spm`, `busy`, `done` = 0.
- `result`, `spm_id`, `lay_*` = 0.
- `next_id` = 1.

Success latency, request cycle = T:
- T+1: VALIDATE.
- T+2: COMMIT (`update_spm` = 1).
- T+3: DONE (`done` = 1).
- T+4: IDLE, ready for a new request.

Failure latency: `done` at T+2. A request accepted at T+3 (DONE) is ignored.

Signal validity:
- `spm_id` and `enable_spm` are driven only in COMMIT; 0 elsewhere.
- `result` holds its value only in DONE; 0 elsewhere.
- `lay_*` hold from T+1 until the next accepted request.

`violation` handling:
- Sampled only in VALIDATE.
- A violation in COMMIT or DONE does not cancel the issued update.

`puc_rst` mid-operation: returns immediately to the reset state. No `update_spm` or `done` is emitted afterwards, and the ID counter returns to 1.

## Test plan
- Protect with `r12`=0x8000, `r13`=0x8100, `r14`=0x0200, `r15`=0x0280, `spms_enabled`=0000 -> `update_spm`=1 and `enable_spm`=1 at T+2, `spm_id`=1. Then `done` and `result`=0x0001 at T+3.
- Second protect, same layout, overlap bit 0 set -> `done` at T+2, `result`=0, no `update_spm`, `next_id` stays 2.
- Inverted public range (`r12`=0x8100, `r13`=0x8000) -> fail, `result`=0.
- Array full (`spms_enabled`=1111) -> fail, `result`=0.
- Secret region overlapping public region (`r14`=0x80F0) -> fail, `result`=0.
- Unprotect -> `update_spm`=1 and `enable_spm`=0 at T+2, `result`=1 at T+3.
- Both requests asserted in the same cycle -> fail, `result`=0.
- Request pulse during `busy` -> ignored.
- `violation`=1 during VALIDATE -> `result`=0, no update.
- ID counter wrap: preload the counter by forcing 0xFFFF, do a successful protect -> `spm_id`=0xFFFF; the next successful protect gives `spm_id`=1.
- `puc_rst` asserted at T+1 of a protect -> no `update_spm`, all outputs 0; the next successful protect gives `spm_id`=1.

Source files
------------

// File: rtl/omsp_spm_protect_ctrl.sv
// rtl/omsp_spm_protect_ctrl.sv - SPM create/destroy request sequencer
// Latches the layout, validates it against the array, issues one update strobe, returns a result.
module omsp_spm_protect_ctrl #(
  parameter int NB_SPMS = 4,
  parameter int ID_W    = 16
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic               req_protect,
  input  logic               req_unprotect,
  input  logic [15:0]        r12,
  input  logic [15:0]        r13,
  input  logic [15:0]        r14,
  input  logic [15:0]        r15,
  input  logic [NB_SPMS-1:0] spms_enabled,
  input  logic [NB_SPMS-1:0] spms_overlap,
  input  logic               violation,
  output logic [15:0]        lay_pub_start,
  output logic [15:0]        lay_pub_end,
  output logic [15:0]        lay_sec_start,
  output logic [15:0]        lay_sec_end,
  output logic               update_spm,
  output logic               enable_spm,
  output logic [ID_W-1:0]    spm_id,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    result
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_VALIDATE = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]      state;
  logic            op_protect;
  logic [ID_W-1:0] next_id;
  logic [ID_W-1:0] result_q;
  logic            layout_ok;
  logic            ok;

  always_comb begin
    layout_ok = (lay_pub_start < lay_pub_end) &&
                (lay_sec_start <= lay_sec_end) &&
                ((lay_sec_end <= lay_pub_start) || (lay_sec_start >= lay_pub_end)) &&
                (~&spms_enabled) && (~|spms_overlap);
    ok = op_protect ? layout_ok : 1'b1;
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state         <= S_IDLE;
      op_protect    <= 1'b0;
      next_id       <= ID_W'(1);
      result_q      <= '0;
      lay_pub_start <= '0;
      lay_pub_end   <= '0;
      lay_sec_start <= '0;
      lay_sec_end   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_protect ^ req_unprotect) begin
            lay_pub_start <= r12;
            lay_pub_end   <= r13;
            lay_sec_start <= r14;
            lay_sec_end   <= r15;
            op_protect    <= req_protect;
            state         <= S_VALIDATE;
          end else if (req_protect && req_unprotect) begin
            result_q <= '0;
            state    <= S_DONE;
          end
        end
        S_VALIDATE: begin
          if (ok && !violation) begin
            state <= S_COMMIT;
          end else begin
            result_q <= '0;
            state    <= S_DONE;
          end
        end
        S_COMMIT: begin
          result_q <= op_protect ? next_id : ID_W'(1);
          // ID 0 means failure, so the counter skips it on wrap
          if (op_protect) begin
            next_id <= (next_id == {ID_W{1'b1}}) ? ID_W'(1) : next_id + ID_W'(1);
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign update_spm = (state == S_COMMIT);
  assign enable_spm = update_spm & op_protect;
  assign spm_id     = update_spm ? next_id : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign result     = done ? result_q : '0;

endmodule

// File: tb/tb_omsp_spm_protect_ctrl.sv
// tb/tb_omsp_spm_protect_ctrl.sv - scoreboard bench for omsp_spm_protect_ctrl
module tb_omsp_spm_protect_ctrl;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        req_protect = 1'b0;
  logic        req_unprotect = 1'b0;
  logic [15:0] r12 = '0, r13 = '0, r14 = '0, r15 = '0;
  logic [3:0]  spms_enabled = '0;
  logic [3:0]  spms_overlap = '0;
  logic        violation = 1'b0;
  logic [15:0] lay_pub_start, lay_pub_end, lay_sec_start, lay_sec_end;
  logic        update_spm, enable_spm, busy, done;
  logic [15:0] spm_id, result;

  int checks = 0;
  int errors = 0;
  logic [16:0] upd_q[$];
  logic [15:0] res_q[$];
  logic [15:0] nid = 16'd1;

  omsp_spm_protect_ctrl #(.NB_SPMS(4), .ID_W(16)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .req_protect(req_protect), .req_unprotect(req_unprotect),
    .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .spms_enabled(spms_enabled), .spms_overlap(spms_overlap), .violation(violation),
    .lay_pub_start(lay_pub_start), .lay_pub_end(lay_pub_end),
    .lay_sec_start(lay_sec_start), .lay_sec_end(lay_sec_end),
    .update_spm(update_spm), .enable_spm(enable_spm), .spm_id(spm_id),
    .busy(busy), .done(done), .result(result)
  );

  always #5 mclk = ~mclk;

  // Output monitor: every update/done must match the next scoreboard entry
  always @(negedge mclk) begin
    if (!puc_rst) begin
      if (update_spm) begin
        checks++;
        if (upd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update enable=%0d id=%h", enable_spm, spm_id);
        end else begin
          logic [16:0] e;
          e = upd_q.pop_front();
          if ({enable_spm, spm_id} !== e) begin
            errors++;
            $display("FAIL update_cmd got en=%0d id=%h expected en=%0d id=%h", enable_spm, spm_id, e[16], e[15:0]);
          end
        end
      end else if (spm_id !== 16'h0 || enable_spm !== 1'b0) begin
        checks++; errors++;
        $display("FAIL idle_cmd got en=%0d id=%h expected 0", enable_spm, spm_id);
      end
      if (done) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done result=%h", result);
        end else begin
          logic [15:0] r;
          r = res_q.pop_front();
          if (result !== r) begin
            errors++;
            $display("FAIL result got %h expected %h", result, r);
          end
        end
      end else if (result !== 16'h0) begin
        checks++; errors++;
        $display("FAIL idle_result got %h expected 0", result);
      end
    end
  end

  task automatic set_layout(input logic [15:0] a, b, c, d);
    r12 = a; r13 = b; r14 = c; r15 = d;
  endtask

  // Drives one request, pushes expectations, checks latency and lay_* capture.
  // pulse_at: negedge index at which a stray unprotect pulse is driven (0 = none).
  task automatic do_req(input string name, input logic p, input logic u, input logic exp_ok,
                        input int exp_lat, input int pulse_at);
    int n;
    logic got;
    if (exp_ok) begin
      upd_q.push_back({p, nid});
      res_q.push_back(p ? nid : 16'd1);
      if (p) nid = (nid == 16'hFFFF) ? 16'd1 : nid + 16'd1;
    end else begin
      res_q.push_back(16'h0);
    end
    @(negedge mclk);
    req_protect = p; req_unprotect = u;
    @(negedge mclk);
    req_protect = 1'b0; req_unprotect = 1'b0;
    n = 1; got = 1'b0;
    if (p ^ u) begin
      checks++;
      if ({lay_pub_start, lay_pub_end, lay_sec_start, lay_sec_end} !== {r12, r13, r14, r15}) begin
        errors++;
        $display("FAIL %s lay got %h %h %h %h", name, lay_pub_start, lay_pub_end, lay_sec_start, lay_sec_end);
      end
    end
    while (!got && n <= 8) begin
      if (done) got = 1'b1;
      else begin
        if (n == pulse_at) req_unprotect = 1'b1;
        @(negedge mclk); req_unprotect = 1'b0; n++;
      end
    end
    checks++;
    if (!got || n != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, got ? n : -1, exp_lat);
    end
    if (n == pulse_at) req_unprotect = 1'b1;
    @(negedge mclk);
    req_unprotect = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got %0d expected 0", name, busy);
    end
    @(negedge mclk);
  endtask

  task automatic test_reset;
    puc_rst = 1'b1;
    repeat (2) @(negedge mclk);
    checks++;
    if ({update_spm, enable_spm, busy, done, result, spm_id,
         lay_pub_start, lay_pub_end, lay_sec_start, lay_sec_end} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got upd=%0d en=%0d busy=%0d done=%0d res=%h id=%h", update_spm, enable_spm, busy, done, result, spm_id);
    end
    puc_rst = 1'b0;
    nid = 16'd1;
  endtask

  task automatic test_protect_ok;
    set_layout(16'h8000, 16'h8100, 16'h0200, 16'h0280);
    spms_enabled = 4'b0000;
    do_req("protect_ok", 1'b1, 1'b0, 1'b1, 3, 0);
  endtask

  task automatic test_protect_fails;
    spms_overlap = 4'b0001;
    do_req("overlap", 1'b1, 1'b0, 1'b0, 2, 0);
    spms_overlap = 4'b0000;
    set_layout(16'h8100, 16'h8000, 16'h0200, 16'h0280);
    do_req("inverted_pub", 1'b1, 1'b0, 1'b0, 2, 0);
    set_layout(16'h8000, 16'h8100, 16'h0200, 16'h0280);
    spms_enabled = 4'b1111;
    do_req("array_full", 1'b1, 1'b0, 1'b0, 2, 0);
    spms_enabled = 4'b0000;
    set_layout(16'h8000, 16'h8100, 16'h80F0, 16'h8200);
    do_req("sec_overlaps_pub", 1'b1, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_unprotect;
    spms_enabled = 4'b1111;
    do_req("unprotect", 1'b0, 1'b1, 1'b1, 3, 0);
    spms_enabled = 4'b0000;
  endtask

  task automatic test_both_requests;
    do_req("both_req", 1'b1, 1'b1, 1'b0, 1, 0);
  endtask

  task automatic test_busy_ignore;
    set_layout(16'h4000, 16'h4100, 16'h0300, 16'h0380);
    do_req("pulse_in_validate", 1'b1, 1'b0, 1'b1, 3, 1);
    do_req("pulse_in_done", 1'b1, 1'b0, 1'b1, 3, 3);
  endtask

  task automatic test_violation;
    violation = 1'b1;
    do_req("violation", 1'b1, 1'b0, 1'b0, 2, 0);
    violation = 1'b0;
  endtask

  task automatic test_id_wrap;
    @(negedge mclk);
    force dut.next_id = 16'hFFFF;
    @(posedge mclk);
    #1 release dut.next_id;
    nid = 16'hFFFF;
    do_req("wrap_ffff", 1'b1, 1'b0, 1'b1, 3, 0);
    do_req("wrap_one", 1'b1, 1'b0, 1'b1, 3, 0);
  endtask

  task automatic test_reset_mid_op;
    @(negedge mclk);
    req_protect = 1'b1;
    @(negedge mclk);
    req_protect = 1'b0;
    puc_rst = 1'b1;
    #1;
    checks++;
    if ({update_spm, enable_spm, busy, done, result, spm_id,
         lay_pub_start, lay_pub_end, lay_sec_start, lay_sec_end} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op outputs got upd=%0d busy=%0d done=%0d lay=%h", update_spm, busy, done, lay_pub_start);
    end
    @(negedge mclk);
    puc_rst = 1'b0;
    nid = 16'd1;
    repeat (4) @(negedge mclk);
    do_req("after_reset", 1'b1, 1'b0, 1'b1, 3, 0);
  endtask

  initial begin
    test_reset();
    test_protect_ok();
    test_protect_fails();
    test_unprotect();
    test_both_requests();
    test_busy_ignore();
    test_violation();
    test_id_wrap();
    set_layout(16'h8000, 16'h8100, 16'h0200, 16'h0280);
    test_reset_mid_op();
    repeat (2) @(negedge mclk);
    checks++;
    if (upd_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got upd=%0d res=%0d expected 0", upd_q.size(), res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
